// File: rtl/fixed_pkg.sv
// Shared fixed-point helpers for the ray-march datapath (Q16.16 by default).
// Holds the word format, the vec3 type and small arithmetic helpers.
package fixed_pkg;

  localparam int BITS  = 32;
  localparam int FIXED = 16;

  typedef struct packed {
    logic signed [BITS-1:0] x;
    logic signed [BITS-1:0] y;
    logic signed [BITS-1:0] z;
  } vec3;

  function automatic logic signed [BITS-1:0] to_fixed(input int i);
    logic signed [BITS-1:0] t;
    t = BITS'(i);
    return t <<< FIXED;
  endfunction

  // Full-width product, then drop FIXED fraction bits to return to Q-format.
  function automatic logic signed [BITS-1:0] mult(input logic signed [BITS-1:0] x,
                                                  input logic signed [BITS-1:0] y);
    logic signed [2*BITS-1:0] p;
    p = x * y;
    return BITS'(p >>> FIXED);
  endfunction

  function automatic logic signed [BITS-1:0] abs(input logic signed [BITS-1:0] x);
    return x[BITS-1] ? -x : x;
  endfunction

  function automatic logic signed [BITS-1:0] signed_minimum();
    return {1'b1, {(BITS-1){1'b0}}};
  endfunction

endpackage

// File: rtl/div.sv
// Sequential signed fixed-point divider, one quotient bit per clock (restoring).
// Define DIV_SATURATE_EN to saturate val on overflow / divide-by-zero instead of zeroing it.
module div
  import fixed_pkg::*;
#(
  parameter int WIDTH = BITS,
  parameter int FBITS = FIXED
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic             valid,
  output logic [WIDTH-1:0] val
);

  localparam int STEPS = WIDTH + FBITS;
  localparam int CW    = $clog2(STEPS + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  localparam logic [STEPS-1:0] MAX_POS = {{(FBITS+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic [STEPS-1:0] MIN_MAG = {{FBITS{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]         r_state;
  logic [2*WIDTH-1:0] r_rem;
  logic [2*WIDTH-1:0] r_quo;
  logic [WIDTH-1:0]   r_divisor;
  logic               r_sign;
  logic               r_dz;
  logic [CW-1:0]      r_cnt;
  logic               r_done;
  logic               r_valid;
  logic [WIDTH-1:0]   r_val;

  logic [WIDTH-1:0]   w_absA;
  logic [WIDTH-1:0]   w_absB;
  logic [2*WIDTH:0]   w_remShift;
  logic               w_ge;
  logic [2*WIDTH-1:0] w_diff;
  logic [STEPS-1:0]   w_mag;
  logic               w_ovf;
  logic [WIDTH-1:0]   w_result;
  logic [WIDTH-1:0]   w_badVal;

  assign w_absA = a[WIDTH-1] ? -a : a;
  assign w_absB = b[WIDTH-1] ? -b : b;

  // The shifted dividend sits left-aligned in r_quo; its MSB feeds the remainder
  // while quotient bits fill in from the bottom.
  assign w_remShift = {r_rem, r_quo[2*WIDTH-1]};
  assign w_ge       = w_remShift >= {{(WIDTH+1){1'b0}}, r_divisor};
  assign w_diff     = w_remShift[2*WIDTH-1:0] - {{WIDTH{1'b0}}, r_divisor};

  assign w_mag    = r_quo[STEPS-1:0];
  assign w_ovf    = (w_mag > MAX_POS) && !(r_sign && (w_mag == MIN_MAG));
  assign w_result = r_sign ? -w_mag[WIDTH-1:0] : w_mag[WIDTH-1:0];

`ifdef DIV_SATURATE_EN
  logic r_aSign;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_aSign <= 1'b0;
    else if (r_state == S_IDLE && start)
      r_aSign <= a[WIDTH-1];
  end

  // Divide-by-zero has no quotient sign, so saturate toward the dividend's sign.
  assign w_badVal = (r_dz ? r_aSign : r_sign) ? {1'b1, {(WIDTH-1){1'b0}}}
                                              : {1'b0, {(WIDTH-1){1'b1}}};
`else
  assign w_badVal = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_rem     <= '0;
      r_quo     <= '0;
      r_divisor <= '0;
      r_sign    <= 1'b0;
      r_dz      <= 1'b0;
      r_cnt     <= '0;
      r_done    <= 1'b0;
      r_valid   <= 1'b0;
      r_val     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_rem     <= '0;
            r_quo     <= {w_absA, {WIDTH{1'b0}}};
            r_divisor <= w_absB;
            r_sign    <= a[WIDTH-1] ^ b[WIDTH-1];
            r_dz      <= (b == '0);
            r_cnt     <= '0;
            r_done    <= 1'b0;
            r_valid   <= 1'b0;
            r_state   <= (b == '0) ? S_FIN : S_CALC;
          end
        end
        S_CALC: begin
          r_rem <= w_ge ? w_diff : w_remShift[2*WIDTH-1:0];
          r_quo <= {r_quo[2*WIDTH-2:0], w_ge};
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(STEPS - 1))
            r_state <= S_FIN;
        end
        S_FIN: begin
          r_done  <= 1'b1;
          r_state <= S_IDLE;
          if (r_dz || w_ovf) begin
            r_valid <= 1'b0;
            r_val   <= w_badVal;
          end else begin
            r_valid <= 1'b1;
            r_val   <= w_result;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign done  = r_done;
  assign valid = r_valid;
  assign val   = r_val;

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div: directed and random operands against an integer-arithmetic model.
// Honours DIV_SATURATE_EN in the model when the design is built with it.
module tb_div;

  localparam int W        = 32;
  localparam int FB       = 16;
  localparam int LATENCY  = W + FB + 1;
  localparam int MAXWAIT  = 200;

  logic          clock;
  logic          reset;
  logic          start;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          done;
  logic          valid;
  logic [W-1:0]  val;

  int errorCount = 0;
  int checkCount = 0;

  div dut (
    .clk   (clock),
    .rst   (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .done  (done),
    .valid (valid),
    .val   (val)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] invalidValue(input logic negative);
`ifdef DIV_SATURATE_EN
    return negative ? 32'h8000_0000 : 32'h7FFF_FFFF;
`else
    return (negative === 1'bx) ? 32'hxxxx_xxxx : 32'h0000_0000;
`endif
  endfunction

  // Exact rational quotient in 64-bit integers; SV division truncates toward zero.
  task automatic refDiv(input logic [31:0] aIn, input logic [31:0] bIn,
                        output logic expValid, output logic [31:0] expVal);
    longint num;
    longint den;
    longint quo;
    if (bIn == 32'd0) begin
      expValid = 1'b0;
      expVal   = invalidValue(aIn[31]);
    end else begin
      num = longint'($signed(aIn)) * 65536;
      den = longint'($signed(bIn));
      quo = num / den;
      if (quo > 64'sd2147483647 || quo < -64'sd2147483648) begin
        expValid = 1'b0;
        expVal   = invalidValue(quo < 0);
      end else begin
        expValid = 1'b1;
        expVal   = 32'(quo);
      end
    end
  endtask

  // Issues one division; if pokeAt > 0 a conflicting start is pulsed that many cycles in.
  task automatic applyStimulus(input logic [31:0] aIn, input logic [31:0] bIn, input int pokeAt);
    logic        expValid;
    logic [31:0] expVal;
    int          cycles;
    refDiv(aIn, bIn, expValid, expVal);
    @(negedge clock);
    a     = aIn;
    b     = bIn;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    checkOutput("doneClearedOnStart", {31'd0, done}, 32'd0);
    cycles = 0;
    while (!done && cycles < MAXWAIT) begin
      @(posedge clock);
      #1;
      cycles++;
      if (pokeAt > 0 && cycles == pokeAt) begin
        a     = ~aIn;
        b     = bIn + 32'h0001_0000;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    checkOutput("latency", 32'(cycles), (bIn == 32'd0) ? 32'd1 : 32'(LATENCY));
    checkOutput("valid", {31'd0, valid}, {31'd0, expValid});
    checkOutput("val", val, expVal);
  endtask

  logic [31:0] dirA [10] = '{32'h0006_0000, 32'h0001_0000, 32'h0001_0000, 32'hFFF8_8000,
                             32'h0005_0000, 32'h0000_0000, 32'h0005_0000, 32'h7FFF_0000,
                             32'h8000_0000, 32'h8000_0000};
  logic [31:0] dirB [10] = '{32'h0002_0000, 32'h0003_0000, 32'h0000_4000, 32'h0002_0000,
                             32'hFFFE_0000, 32'h0003_0000, 32'h0000_0000, 32'h0000_0100,
                             32'h0001_0000, 32'hFFFF_0000};

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic        sawDone;

    reset = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("resetDone", {31'd0, done}, 32'd0);
    checkOutput("resetValid", {31'd0, valid}, 32'd0);
    checkOutput("resetVal", val, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 10; i++)
      applyStimulus(dirA[i], dirB[i], 0);

    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 30);
      if ($urandom_range(0, 1) == 1)
        rb = -rb;
      applyStimulus(ra, rb, 0);
    end

    // Abort a division with reset: outputs clear at once and no done follows.
    applyStimulus(32'h0001_0000, 32'h0003_0000, 0);
    @(negedge clock);
    a     = 32'h0006_0000;
    b     = 32'h0002_0000;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midResetDone", {31'd0, done}, 32'd0);
    checkOutput("midResetVal", val, 32'd0);
    @(negedge clock);
    reset   = 1'b0;
    sawDone = 1'b0;
    for (int i = 0; i < LATENCY + 10; i++) begin
      @(posedge clock);
      #1;
      sawDone = sawDone | done;
    end
    checkOutput("noDoneAfterAbort", {31'd0, sawDone}, 32'd0);

    applyStimulus(32'h0006_0000, 32'h0002_0000, 20);
    applyStimulus(32'hFFF8_8000, 32'h0002_0000, 5);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
